ipv4_header_collector: RTL and testbench
========================================

IPV4_HEADER_COLLECTOR -- requirements
Module: ipv4_header_collector

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, which sets the width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-006 SHALL have port in_data, input, 32 bits: big-endian packet word.
REQ-007 SHALL have port in_sop, input, 1 bit: first word of a packet.
REQ-008 SHALL have port in_eop, input, 1 bit: last word of a packet.
REQ-009 SHALL have ports ih1..ih6, output, 32 bits each: collected words 1..6 (five header words plus one data word), driven to the downstream segmentation stage.
REQ-010 SHALL have port out_valid, output, 1 bit: ih1..ih6 hold a complete packet.
REQ-011 SHALL have port out_ack, input, 1 bit: downstream has consumed the packet.
REQ-012 SHALL have port chksum_ok, output, 1 bit: the IPv4 header checksum over ih1..ih5 is valid; qualified by out_valid.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a malformed packet.
REQ-014 SHALL have port err_count, output, ERR_CNT_W bits: saturating count of frame_err pulses.

Function
REQ-015 A word transfer SHALL occur only when in_valid and in_ready are both 1 on a rising edge.
REQ-016 The FSM SHALL have exactly four states: IDLE, COLLECT, HOLD, DROP.
REQ-017 in_ready SHALL be 1 in IDLE, COLLECT and DROP, and SHALL be 0 in HOLD.
REQ-018 In IDLE, a transferred word with in_sop=0 SHALL be discarded with no error.
REQ-019 In IDLE, a word with in_sop=1 and in_eop=0 SHALL be stored to ih1, set the word index to 1, and move the FSM to COLLECT.
REQ-020 In IDLE, a word with in_sop=1 and in_eop=1 SHALL pulse frame_err and the FSM SHALL stay in IDLE.
REQ-021 In COLLECT, a word with in_sop=0 SHALL be stored to ih(index+1) and the index SHALL increment.
REQ-022 In COLLECT, a word with in_sop=1 SHALL pulse frame_err and restart collection: the word goes to ih1, the index is set to 1, and the FSM stays in COLLECT.
REQ-023 In COLLECT, in_eop=1 on words 2..5 SHALL pulse frame_err and move the FSM to IDLE (packet too short).
REQ-024 In COLLECT, when word 6 arrives with in_eop=1, the FSM SHALL move to HOLD, and out_valid SHALL be 1 on the next cycle.
REQ-025 In COLLECT, when word 6 arrives with in_eop=0, the FSM SHALL move to DROP and frame_err SHALL pulse (packet too long).
REQ-026 In DROP, the block SHALL discard words until a word with in_eop=1 is transferred, then move to IDLE, with no further frame_err.
REQ-027 In HOLD, ih1..ih6 and chksum_ok SHALL stay stable.
REQ-028 In HOLD, out_ack=1 SHALL clear out_valid on the next cycle and move the FSM to IDLE; out_ack SHALL be ignored outside HOLD.
REQ-029 The checksum SHALL be a 16-bit ones-complement running sum with end-around carry, accumulating the high and low halves of words 1..5 as they are stored.
REQ-030 The checksum accumulator SHALL clear whenever a word is stored to ih1.
REQ-031 chksum_ok SHALL be registered on entry to HOLD and SHALL equal 1 only when the folded sum equals 16'hFFFF.
REQ-032 err_count SHALL increment on each frame_err pulse and SHALL saturate at all-ones.
REQ-033 Latency from the eop word transfer to out_valid=1 SHALL be exactly one cycle.

Reset
REQ-034 While reset=1, on a clock edge the state SHALL become IDLE, the index 0, the accumulator 0, ih1..ih6 0, and out_valid, chksum_ok, frame_err and err_count 0.
REQ-035 An assertion of reset in any state, including mid-packet or in HOLD, SHALL abandon the packet with no frame_err.
REQ-036 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-037 Feed a good packet: 45010018, 00004000, 7B067BDC, C0000001, C4000001, C4000007 (sop on word 1, eop on word 6). Required: out_valid=1 one cycle later, ih1..ih6 match the inputs, chksum_ok=1, in_ready=0 until out_ack.
REQ-038 Feed the same packet with word 3 = 7B06FCED. Required: out_valid=1 and chksum_ok=0.
REQ-039 Feed a packet with eop on word 4. Required: one frame_err pulse, err_count=1, FSM back in IDLE, no out_valid.
REQ-040 Feed a packet with 8 words and eop on word 8. Required: frame_err pulse after word 6, words 7..8 discarded, then the next good packet is collected correctly.
REQ-041 Hold out_ack=0 for 10 cycles while in_valid=1. Required: in_ready=0 and outputs stable throughout; after out_ack, out_valid=0 and in_ready=1 on the next cycle.
REQ-042 Assert reset after word 3 of a packet, then send a fresh good packet. Required: no frame_err, err_count unchanged at 0, fresh packet delivered with chksum_ok=1.

Source files
------------

// File: rtl/ipv4_header_collector.sv
// ipv4_header_collector
// Collects a six-word packet (five IPv4 header words plus one data word) from a
// valid/ready word stream, checks the IPv4 header checksum on the fly, and holds
// the words stable for a downstream segmentation stage until it acknowledges.
// Malformed packets (bad sop/eop framing, too short, too long) raise a one-cycle
// frame_err pulse and bump a saturating error counter.
module ipv4_header_collector #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_sop,
    input  logic                 in_eop,
    output logic [31:0]          ih1,
    output logic [31:0]          ih2,
    output logic [31:0]          ih3,
    output logic [31:0]          ih4,
    output logic [31:0]          ih5,
    output logic [31:0]          ih6,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 chksum_ok,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [2:0] LAST_HDR_IDX = 3'd5;  // index after the fifth header word

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_idx;
    logic [2:0]            w_idx_next;
    logic [15:0]           r_acc;
    logic [15:0]           w_acc_base;
    logic [15:0]           w_acc_sum;
    logic [31:0]           r_ih [1:6];
    logic                  r_out_valid;
    logic                  r_chksum_ok;
    logic                  r_frame_err;
    logic [ERR_CNT_W-1:0]  r_err_count;

    logic                  w_xfer;
    logic                  w_store;
    logic [2:0]            w_store_sel;
    logic                  w_acc_upd;
    logic                  w_acc_clr;
    logic                  w_err;

    // 16-bit ones-complement add with end-around carry; the carry re-add can
    // never overflow again, because the largest raw sum is 0x1FFFE.
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    assign in_ready = (r_state != HOLD);
    assign w_xfer   = in_valid && in_ready;

    // A word stored to ih1 starts a fresh sum; later header words add onto it.
    assign w_acc_base = w_acc_clr ? 16'h0000 : r_acc;
    assign w_acc_sum  = oc_add(oc_add(w_acc_base, in_data[31:16]), in_data[15:0]);

    // Next-state, word-store and error decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        w_next      = r_state;
        w_idx_next  = r_idx;
        w_store     = 1'b0;
        w_store_sel = 3'd1;
        w_acc_upd   = 1'b0;
        w_acc_clr   = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_xfer && in_sop) begin
                    if (in_eop) begin
                        w_err = 1'b1;                 // single-word packet
                    end else begin
                        w_store    = 1'b1;
                        w_acc_clr  = 1'b1;
                        w_acc_upd  = 1'b1;
                        w_idx_next = 3'd1;
                        w_next     = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (w_xfer) begin
                    if (in_sop) begin
                        // Unexpected start: flag it and restart on this word.
                        w_err      = 1'b1;
                        w_store    = 1'b1;
                        w_acc_clr  = 1'b1;
                        w_acc_upd  = 1'b1;
                        w_idx_next = 3'd1;
                    end else if (r_idx == LAST_HDR_IDX) begin
                        // Sixth word: the data word, not part of the checksum.
                        w_store     = 1'b1;
                        w_store_sel = 3'd6;
                        w_idx_next  = 3'd6;
                        if (in_eop) begin
                            w_next = HOLD;
                        end else begin
                            w_err  = 1'b1;            // packet too long
                            w_next = DROP;
                        end
                    end else if (in_eop) begin
                        w_err      = 1'b1;            // packet too short
                        w_idx_next = 3'd0;
                        w_next     = IDLE;
                    end else begin
                        w_store     = 1'b1;
                        w_store_sel = r_idx + 3'd1;
                        w_acc_upd   = 1'b1;
                        w_idx_next  = r_idx + 3'd1;
                    end
                end
            end

            HOLD: begin
                if (out_ack) begin
                    w_idx_next = 3'd0;
                    w_next     = IDLE;
                end
            end

            DROP: begin
                if (w_xfer && in_eop) begin
                    w_idx_next = 3'd0;
                    w_next     = IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, word index and checksum accumulator registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_acc   <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            if (w_acc_upd) begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // Collected word registers, written one slot per accepted word.
    always_ff @(posedge clk) begin
        // NOTE: this word storage is cleared on reset on purpose, because its contents are visible on the outputs.
        if (reset) begin
            for (int i = 1; i <= 6; i++) begin
                r_ih[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 1; i <= 6; i++) begin
                if (w_store && (w_store_sel == 3'(i))) begin
                    r_ih[i] <= in_data;
                end
            end
        end
    end

    // Output flags: out_valid mirrors HOLD; chksum_ok is latched on HOLD entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_chksum_ok <= 1'b0;
        end else begin
            r_out_valid <= (w_next == HOLD);
            if ((r_state == COLLECT) && (w_next == HOLD)) begin
                r_chksum_ok <= (r_acc == 16'hFFFF);
            end
        end
    end

    // frame_err pulse and its saturating counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_frame_err <= w_err;
            if (w_err && !(&r_err_count)) begin
                r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ih1       = r_ih[1];
    assign ih2       = r_ih[2];
    assign ih3       = r_ih[3];
    assign ih4       = r_ih[4];
    assign ih5       = r_ih[5];
    assign ih6       = r_ih[6];
    assign out_valid = r_out_valid;
    assign chksum_ok = r_chksum_ok;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_ipv4_header_collector.sv
// tb_ipv4_header_collector
// Directed scenarios plus randomized packet traffic, compared every cycle
// against a packet-level reference model (queue of words collected so far).
module tb_ipv4_header_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [31:0] ih1, ih2, ih3, ih4, ih5, ih6;
    logic        out_valid;
    logic        out_ack;
    logic        chksum_ok;
    logic        frame_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_words[$];
    logic [31:0] m_ih[6];
    bit          m_hold;
    bit          m_drop;
    bit          m_ok;
    bit          m_err;
    int          m_cnt;

    logic [31:0] pkt[16];

    always #5 clk = ~clk;

    ipv4_header_collector #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .ih1       (ih1),
        .ih2       (ih2),
        .ih3       (ih3),
        .ih4       (ih4),
        .ih5       (ih5),
        .ih6       (ih6),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .chksum_ok (chksum_ok),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // IPv4 checksum rule: ones-complement sum of the ten 16-bit halves of
    // words 1..5 is all-ones.
    function automatic bit hdr_ok();
        int unsigned s = 0;
        for (int i = 0; i < 5; i++) begin
            s += m_words[i][31:16];
            s += m_words[i][15:0];
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s == 32'hFFFF;
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_hold = 0;
        m_drop = 0;
        m_ok   = 0;
        m_err  = 0;
        m_cnt  = 0;
        for (int i = 0; i < 6; i++) m_ih[i] = 32'h0;
    endtask

    // Packet-level behaviour for one clock edge.
    task automatic model_update(input bit v, input logic [31:0] d, input bit sop, input bit eop, input bit ack);
        m_err = 0;
        if (m_hold) begin
            if (ack) m_hold = 0;
        end else if (v) begin
            if (m_drop) begin
                if (eop) m_drop = 0;
            end else if (m_words.size() == 0) begin
                if (sop && eop) m_err = 1;
                else if (sop) m_words.push_back(d);
            end else if (sop) begin
                m_err = 1;
                m_words.delete();
                m_words.push_back(d);
            end else begin
                m_words.push_back(d);
                if (m_words.size() == 6) begin
                    if (eop) begin
                        m_hold = 1;
                        for (int i = 0; i < 6; i++) m_ih[i] = m_words[i];
                        m_ok = hdr_ok();
                    end else begin
                        m_err  = 1;
                        m_drop = 1;
                    end
                    m_words.delete();
                end else if (eop) begin
                    m_err = 1;
                    m_words.delete();
                end
            end
        end
        if (m_err && m_cnt != 255) m_cnt++;
    endtask

    task automatic compare();
        check("in_ready",  32'(in_ready),  32'(!m_hold));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("frame_err", 32'(frame_err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_cnt));
        if (m_hold) begin
            check("ih1", ih1, m_ih[0]);
            check("ih2", ih2, m_ih[1]);
            check("ih3", ih3, m_ih[2]);
            check("ih4", ih4, m_ih[3]);
            check("ih5", ih5, m_ih[4]);
            check("ih6", ih6, m_ih[5]);
            check("chksum_ok", 32'(chksum_ok), 32'(m_ok));
        end
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic step(input bit v, input logic [31:0] d, input bit sop, input bit eop, input bit ack);
        in_valid = v;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        out_ack  = ack;
        @(posedge clk);
        model_update(v, d, sop, eop, ack);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        out_ack  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_chksum_ok", 32'(chksum_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_ih1", ih1, 32'h0);
        check("rst_ih3", ih3, 32'h0);
        check("rst_ih6", ih6, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) step(1'b1, pkt[i], i == 0, i == n - 1, 1'b0);
    endtask

    task automatic load_good();
        pkt[0] = 32'h45010018; pkt[1] = 32'h00004000; pkt[2] = 32'h7B067BDC;
        pkt[3] = 32'hC0000001; pkt[4] = 32'hC4000001; pkt[5] = 32'hC4000007;
        pkt[6] = 32'h11112222; pkt[7] = 32'h33334444;
    endtask

    // Overwrite the low half of word 3 so the header sums to all-ones.
    task automatic fix_checksum();
        int unsigned s = 0;
        pkt[2][15:0] = 16'h0000;
        for (int i = 0; i < 5; i++) s += pkt[i][31:16] + pkt[i][15:0];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        pkt[2][15:0] = ~s[15:0];
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        out_ack  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Good packet, then a long HOLD with traffic pending, then ack.
        load_good();
        send_pkt(6);
        check("good_valid", 32'(out_valid), 32'd1);
        check("good_ok",    32'(chksum_ok), 32'd1);
        check("good_ih1",   ih1, 32'h45010018);
        check("good_ih6",   ih6, 32'hC4000007);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        check("hold_ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        check("ack_valid", 32'(out_valid), 32'd0);
        check("ack_ready", 32'(in_ready),  32'd1);

        // Corrupted checksum.
        load_good();
        pkt[2] = 32'h7B06FCED;
        send_pkt(6);
        check("bad_valid", 32'(out_valid), 32'd1);
        check("bad_ok",    32'(chksum_ok), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Too short: eop on word 4.
        load_good();
        send_pkt(4);
        check("short_cnt", 32'(err_count), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("short_novalid", 32'(out_valid), 32'd0);

        // Too long: eight words, then a good packet.
        load_good();
        send_pkt(8);
        check("long_cnt", 32'(err_count), 32'd2);
        load_good();
        send_pkt(6);
        check("after_long_ok", 32'(chksum_ok), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset mid-packet, then a fresh good packet.
        do_reset();
        load_good();
        step(1'b1, pkt[0], 1'b1, 1'b0, 1'b0);
        step(1'b1, pkt[1], 1'b0, 1'b0, 1'b0);
        step(1'b1, pkt[2], 1'b0, 1'b0, 1'b0);
        do_reset();
        send_pkt(6);
        check("midrst_cnt", 32'(err_count), 32'd0);
        check("midrst_ok",  32'(chksum_ok), 32'd1);

        // Reset while holding a packet.
        do_reset();

        // Counter saturation: single-word sop+eop packets in IDLE.
        for (int i = 0; i < 300; i++) step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        check("sat_cnt", 32'(err_count), 32'h0000_00FF);

        // Randomized traffic.
        do_reset();
        for (int p = 0; p < 250; p++) begin
            int n;
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) pkt[i] = $urandom;
            if (n >= 6 && ($urandom % 2 == 0)) fix_checksum();
            for (int i = 0; i < n; i++) begin
                while ($urandom % 5 == 0) step(1'b0, $urandom, 1'b0, 1'b0, ($urandom % 4) == 0);
                step(1'b1, pkt[i],
                     (i == 0)     || ($urandom % 30 == 0),
                     (i == n - 1) || ($urandom % 30 == 0),
                     ($urandom % 4) == 0);
            end
            step(1'b0, 32'h0, 1'b0, 1'b0, ($urandom % 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
